// File: rtl/missile_gfx_pkg.sv
// Shared types and constants for the missile-command graphics path.
package missile_gfx_pkg;

    // Default geometry of the VGA plot path.
    localparam int DEF_X_W     = 9;
    localparam int DEF_Y_W     = 8;
    localparam int DEF_COLOR_W = 3;
    localparam int SCREEN_W    = 320;
    localparam int SCREEN_H    = 240;

    // Palette used by the drawing FSMs.
    localparam logic [DEF_COLOR_W-1:0] BACK    = 3'b000;
    localparam logic [DEF_COLOR_W-1:0] CITY    = 3'b010;
    localparam logic [DEF_COLOR_W-1:0] MISSILE = 3'b101;
    localparam logic [DEF_COLOR_W-1:0] DEFAULT = 3'b111;

    // One queued rectangle command at the default widths.
    typedef struct packed {
        logic [DEF_X_W-1:0]     x;
        logic [DEF_Y_W-1:0]     y;
        logic [DEF_X_W-1:0]     w;
        logic [DEF_Y_W-1:0]     h;
        logic [DEF_COLOR_W-1:0] color;
        logic                   outline;
    } rect_cmd_t;

    // Rectangle engine sequencing.
    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAW,
        S_DONE
    } state_t;

endpackage

// File: rtl/rect_cmd_fifo.sv
// Small synchronous command FIFO with first-word fall-through read data.
module rect_cmd_fifo
    import missile_gfx_pkg::*;
#(
    parameter int  DEPTH  = 4,
    parameter type item_t = rect_cmd_t
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  logic  pop,
    input  item_t wdata,
    output item_t rdata,
    output logic  full,
    output logic  empty
);

    localparam int AW = $clog2(DEPTH);

    item_t       mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    // The extra pointer bit tells full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Pointer update; reset empties the queue.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the pointers alone decide which entries are valid.
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/rect_fill_engine.sv
// Queued rectangle rasteriser: one clipped pixel write per cycle into the VGA adapter.
module rect_fill_engine
    import missile_gfx_pkg::*;
#(
    parameter int X_W        = DEF_X_W,
    parameter int Y_W        = DEF_Y_W,
    parameter int COLOR_W    = DEF_COLOR_W,
    parameter int SCREEN_W   = missile_gfx_pkg::SCREEN_W,
    parameter int SCREEN_H   = missile_gfx_pkg::SCREEN_H,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [X_W-1:0]     cmd_x,
    input  logic [Y_W-1:0]     cmd_y,
    input  logic [X_W-1:0]     cmd_w,
    input  logic [Y_W-1:0]     cmd_h,
    input  logic [COLOR_W-1:0] cmd_color,
    input  logic               cmd_outline,
    input  logic               pix_stall,
    output logic [X_W-1:0]     pix_x,
    output logic [Y_W-1:0]     pix_y,
    output logic [COLOR_W-1:0] pix_color,
    output logic               plot,
    output logic               busy,
    output logic               rect_done
);

    typedef struct packed {
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic [X_W-1:0]     w;
        logic [Y_W-1:0]     h;
        logic [COLOR_W-1:0] color;
        logic               outline;
    } cmd_t;

    localparam logic [X_W:0] SCR_W = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] SCR_H = (Y_W+1)'(SCREEN_H);

    state_t         state;
    state_t         state_next;
    cmd_t           cmd_in;
    cmd_t           fifo_head;
    cmd_t           cur;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_push;
    logic           fifo_pop;
    logic [X_W-1:0] cx;
    logic [Y_W-1:0] cy;
    logic [X_W:0]   xe;
    logic [Y_W:0]   ye;
    logic [X_W:0]   x_end;
    logic [Y_W:0]   y_end;
    logic [X_W:0]   x_last;
    logic [Y_W:0]   y_last;
    logic [X_W:0]   cx_inc;
    logic [Y_W:0]   cy_inc;
    logic           load_skip;
    logic           row_end;
    logic           last_pix;
    logic           edge_ok;
    logic           advance;

    assign cmd_in    = '{x: cmd_x, y: cmd_y, w: cmd_w, h: cmd_h,
                         color: cmd_color, outline: cmd_outline};
    assign cmd_ready = !fifo_full && !rst;
    assign fifo_push = cmd_valid && cmd_ready;
    assign busy      = (state != S_IDLE) || !fifo_empty;

    rect_cmd_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .item_t (cmd_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (cmd_in),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // One-bit-wider sums so a rectangle running off the screen edge cannot wrap.
    assign x_end     = {1'b0, cur.x} + {1'b0, cur.w};
    assign y_end     = {1'b0, cur.y} + {1'b0, cur.h};
    assign x_last    = x_end - 1'b1;
    assign y_last    = y_end - 1'b1;
    assign load_skip = (cur.w == '0) || (cur.h == '0) ||
                       ({1'b0, cur.x} >= SCR_W) || ({1'b0, cur.y} >= SCR_H);

    assign cx_inc   = {1'b0, cx} + 1'b1;
    assign cy_inc   = {1'b0, cy} + 1'b1;
    assign row_end  = (cx_inc == xe);
    assign last_pix = row_end && (cy_inc == ye);
    assign advance  = (state == S_DRAW) && !pix_stall;

    // Outline edges use the unclipped rectangle, so a clipped side simply has no border.
    assign edge_ok = !cur.outline ||
                     (cx == cur.x) || ({1'b0, cx} == x_last) ||
                     (cy == cur.y) || ({1'b0, cy} == y_last);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state and FIFO pop decode.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_next = state;
        fifo_pop   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = S_LOAD;
                end
            end
            S_LOAD: state_next = load_skip ? S_DONE : S_DRAW;
            S_DRAW: if (advance && last_pix) state_next = S_DONE;
            S_DONE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = S_LOAD;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Command latch, clip limits and scan counters; LOAD initialises all of it before DRAW.
    always_ff @(posedge clk) begin
        if (fifo_pop) cur <= fifo_head;
        if (state == S_LOAD) begin
            cx <= cur.x;
            cy <= cur.y;
            xe <= (x_end > SCR_W) ? SCR_W : x_end;
            ye <= (y_end > SCR_H) ? SCR_H : y_end;
        end else if (advance) begin
            if (row_end) begin
                cx <= cur.x;
                cy <= cy_inc[Y_W-1:0];
            end else begin
                cx <= cx_inc[X_W-1:0];
            end
        end
    end

    // Registered pixel port and completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_x     <= '0;
            pix_y     <= '0;
            pix_color <= '0;
            plot      <= 1'b0;
            rect_done <= 1'b0;
        end else begin
            plot      <= advance && edge_ok;
            rect_done <= (state == S_DONE);
            if (advance) begin
                pix_x     <= cx;
                pix_y     <= cy;
                pix_color <= cur.color;
            end
        end
    end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Directed self-checking bench for rect_fill_engine.
module tb_rect_fill_engine;
    import missile_gfx_pkg::*;

    localparam int X_W     = 9;
    localparam int Y_W     = 8;
    localparam int COLOR_W = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [X_W-1:0]     cmd_x;
    logic [Y_W-1:0]     cmd_y;
    logic [X_W-1:0]     cmd_w;
    logic [Y_W-1:0]     cmd_h;
    logic [COLOR_W-1:0] cmd_color;
    logic               cmd_outline;
    logic               pix_stall;
    logic [X_W-1:0]     pix_x;
    logic [Y_W-1:0]     pix_y;
    logic [COLOR_W-1:0] pix_color;
    logic               plot;
    logic               busy;
    logic               rect_done;

    rect_fill_engine dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_x       (cmd_x),
        .cmd_y       (cmd_y),
        .cmd_w       (cmd_w),
        .cmd_h       (cmd_h),
        .cmd_color   (cmd_color),
        .cmd_outline (cmd_outline),
        .pix_stall   (pix_stall),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_color   (pix_color),
        .plot        (plot),
        .busy        (busy),
        .rect_done   (rect_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int c;
        int cyc;
    } plot_t;

    int    cyc = 0;
    int    done_cnt = 0;
    int    n_tests = 0;
    int    n_fail = 0;
    plot_t plog[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Record every plotted pixel and every completion pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (plot) plog.push_back('{x: int'(pix_x), y: int'(pix_y), c: int'(pix_color), cyc: cyc});
        if (rect_done) done_cnt++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to just after the next falling edge, after the monitor has run.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Offer a command and hold it until accepted; returns the accepting edge count.
    task automatic push_cmd(input int x, input int y, input int w, input int h,
                            input int c, input int o, output int acc_cyc);
        int waited = 0;
        cmd_valid   = 1'b1;
        cmd_x       = x[X_W-1:0];
        cmd_y       = y[Y_W-1:0];
        cmd_w       = w[X_W-1:0];
        cmd_h       = h[Y_W-1:0];
        cmd_color   = c[COLOR_W-1:0];
        cmd_outline = o[0];
        while (!cmd_ready && waited < 500) begin
            step();
            waited++;
        end
        check("push_wait", int'(waited < 500), 1);
        step();
        acc_cyc = cyc;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n = 0;
        while ((busy || plot || rect_done) && n < max) begin
            step();
            n++;
        end
        check(tag, int'(n < max), 1);
    endtask

    task automatic wait_plots(input string tag, input int target, input int max);
        int n = 0;
        while (plog.size() < target && n < max) begin
            step();
            n++;
        end
        check(tag, int'(n < max), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        int b;
        int d0;
        int p0;
        int seen;

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0;
        cmd_color = '0; cmd_outline = 1'b0;
        pix_stall = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Reset state.
        check("rst_plot", int'(plot), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(rect_done), 0);
        check("rst_ready", int'(cmd_ready), 1);
        check("rst_pix_x", int'(pix_x), 0);

        // 1: 2x2 solid fill, first plot three edges after the push.
        b = plog.size(); d0 = done_cnt;
        push_cmd(10, 20, 2, 2, int'(CITY), 0, t);
        cmd_valid = 1'b0;
        wait_idle("t1_idle", 50);
        check("t1_count", plog.size() - b, 4);
        check("t1_done", done_cnt - d0, 1);
        if (plog.size() - b == 4) begin
            check("t1_lat", plog[b].cyc, t + 3);
            check("t1_p0x", plog[b].x, 10);   check("t1_p0y", plog[b].y, 20);
            check("t1_p1x", plog[b+1].x, 11); check("t1_p1y", plog[b+1].y, 20);
            check("t1_p2x", plog[b+2].x, 10); check("t1_p2y", plog[b+2].y, 21);
            check("t1_p3x", plog[b+3].x, 11); check("t1_p3y", plog[b+3].y, 21);
            check("t1_last_cyc", plog[b+3].cyc, t + 6);
            check("t1_color", plog[b+2].c, 2);
        end

        // 2: rectangle hanging off the bottom-right corner.
        b = plog.size(); d0 = done_cnt;
        push_cmd(318, 238, 5, 5, int'(DEFAULT), 0, t);
        cmd_valid = 1'b0;
        wait_idle("t2_idle", 50);
        check("t2_count", plog.size() - b, 4);
        check("t2_done", done_cnt - d0, 1);
        if (plog.size() - b == 4) begin
            check("t2_p0x", plog[b].x, 318);   check("t2_p0y", plog[b].y, 238);
            check("t2_p1x", plog[b+1].x, 319); check("t2_p1y", plog[b+1].y, 238);
            check("t2_p2x", plog[b+2].x, 318); check("t2_p2y", plog[b+2].y, 239);
            check("t2_p3x", plog[b+3].x, 319); check("t2_p3y", plog[b+3].y, 239);
        end

        // 3: 4x3 outline; interior (1,1),(2,1) scanned but not plotted.
        b = plog.size(); d0 = done_cnt;
        push_cmd(0, 0, 4, 3, int'(MISSILE), 1, t);
        cmd_valid = 1'b0;
        wait_idle("t3_idle", 50);
        check("t3_count", plog.size() - b, 10);
        check("t3_done", done_cnt - d0, 1);
        seen = 0;
        for (int i = b; i < plog.size(); i++)
            if (plog[i].y == 1 && (plog[i].x == 1 || plog[i].x == 2)) seen++;
        check("t3_interior", seen, 0);
        if (plog.size() - b == 10) begin
            check("t3_span", plog[b+9].cyc - plog[b].cyc + 1, 12);
            check("t3_p4x", plog[b+4].x, 0); check("t3_p4y", plog[b+4].y, 1);
            check("t3_p5x", plog[b+5].x, 3); check("t3_p5y", plog[b+5].y, 1);
            check("t3_p9x", plog[b+9].x, 3); check("t3_p9y", plog[b+9].y, 2);
        end

        // 4: queue fills behind a long 10x10 fill; all five drawn in order.
        b = plog.size(); d0 = done_cnt;
        push_cmd(100, 100, 10, 10, 7, 0, t);
        push_cmd(200, 50, 1, 1, 1, 0, t);
        push_cmd(201, 50, 1, 1, 2, 0, t);
        push_cmd(202, 50, 1, 1, 3, 0, t);
        check("t4_ready_before_4th", int'(cmd_ready), 1);
        push_cmd(203, 50, 1, 1, 4, 0, t);
        cmd_valid = 1'b0;
        check("t4_ready_full", int'(cmd_ready), 0);
        check("t4_busy", int'(busy), 1);
        wait_idle("t4_idle", 400);
        check("t4_count", plog.size() - b, 104);
        check("t4_done", done_cnt - d0, 5);
        if (plog.size() - b == 104) begin
            check("t4_a_lastx", plog[b+99].x, 109);
            check("t4_a_lasty", plog[b+99].y, 109);
            for (int k = 0; k < 4; k++) begin
                check($sformatf("t4_q%0d_x", k), plog[b+100+k].x, 200 + k);
                check($sformatf("t4_q%0d_c", k), plog[b+100+k].c, k + 1);
            end
        end

        // 5: stall three cycles mid-row of an 8x1 fill.
        b = plog.size(); d0 = done_cnt;
        push_cmd(50, 60, 8, 1, int'(MISSILE), 0, t);
        cmd_valid = 1'b0;
        wait_plots("t5_start", b + 3, 50);
        pix_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("t5_stall_plot%0d", k), int'(plot), 0);
        end
        pix_stall = 1'b0;
        wait_idle("t5_idle", 50);
        check("t5_count", plog.size() - b, 8);
        check("t5_done", done_cnt - d0, 1);
        if (plog.size() - b == 8) begin
            for (int k = 0; k < 8; k++)
                check($sformatf("t5_x%0d", k), plog[b+k].x, 50 + k);
            check("t5_span", plog[b+7].cyc - plog[b].cyc + 1, 11);
        end

        // 6: empty and off-screen commands, then reset during a 20x20 fill.
        b = plog.size(); d0 = done_cnt;
        push_cmd(5, 5, 0, 3, 1, 0, t);
        push_cmd(400, 10, 5, 5, 1, 0, t);
        cmd_valid = 1'b0;
        wait_idle("t6_idle", 50);
        check("t6_skip_plots", plog.size() - b, 0);
        check("t6_skip_done", done_cnt - d0, 2);

        b = plog.size();
        push_cmd(0, 0, 20, 20, int'(CITY), 0, t);
        push_cmd(40, 40, 2, 2, int'(CITY), 0, t);
        cmd_valid = 1'b0;
        wait_plots("t6_start", b + 5, 50);
        d0 = done_cnt;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        check("t6_rst_plot", int'(plot), 0);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_ready", int'(cmd_ready), 1);
        p0 = plog.size();
        repeat (30) step();
        check("t6_no_plot_after", plog.size() - p0, 0);
        check("t6_no_done", done_cnt - d0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
